// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - opcode, next-PC and write-data constants plus source-register usage decode
package id_ex_stage_pkg;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_B_TYPE = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JAL  = 2'b10;
  localparam logic [1:0] NPC_JALR = 2'b11;

  localparam logic [1:0] WD_DRAM  = 2'b10;

  // Returns {uses_rs2, uses_rs1}; unknown opcodes read nothing so they can never stall.
  function automatic logic [1:0] src_use(input logic [6:0] op);
    case (op)
      OP_R_TYPE, OP_SW, OP_B_TYPE: src_use = 2'b11;
      OP_I_TYPE, OP_LW, OP_JALR:   src_use = 2'b01;
      default:                     src_use = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// rtl/id_ex_stage_hazard_detect.sv - combinational load-use hazard flag between the EX load and the ID consumer
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int REGW = 5
) (
  input  logic [6:0]      id_opcode_i,
  input  logic [REGW-1:0] id_rs1_i,
  input  logic [REGW-1:0] id_rs2_i,
  input  logic            id_valid_i,
  input  logic            ex_valid_i,
  input  logic            ex_rf_we_i,
  input  logic [1:0]      ex_wd_sel_i,
  input  logic [REGW-1:0] ex_rd_i,
  output logic            hazard_o
);

  logic [1:0] use_rs;
  logic       ex_is_load;

  always_comb begin
    use_rs     = src_use(id_opcode_i);
    ex_is_load = ex_valid_i && ex_rf_we_i && (ex_wd_sel_i == WD_DRAM) && (ex_rd_i != '0);
    hazard_o   = ex_is_load && id_valid_i &&
                 ((use_rs[0] && (id_rs1_i == ex_rd_i)) ||
                  (use_rs[1] && (id_rs2_i == ex_rd_i)));
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall, flush-to-bubble and bubble counter
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      id_opcode_i,
  input  logic [1:0]      id_npc_op_i,
  input  logic            id_rf_we_i,
  input  logic [1:0]      id_wd_sel_i,
  input  logic [2:0]      id_sext_op_i,
  input  logic [2:0]      id_alu_op_i,
  input  logic            id_alub_sel_i,
  input  logic            id_branch_i,
  input  logic            id_dram_we_i,
  input  logic [1:0]      id_b_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_rd1_i,
  input  logic [XLEN-1:0] id_rd2_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [REGW-1:0] id_rs1_i,
  input  logic [REGW-1:0] id_rs2_i,
  input  logic [REGW-1:0] id_rd_i,
  input  logic            id_valid_i,
  input  logic            flush_i,
  output logic [6:0]      ex_opcode_o,
  output logic [1:0]      ex_npc_op_o,
  output logic            ex_rf_we_o,
  output logic [1:0]      ex_wd_sel_o,
  output logic [2:0]      ex_sext_op_o,
  output logic [2:0]      ex_alu_op_o,
  output logic            ex_alub_sel_o,
  output logic            ex_branch_o,
  output logic            ex_dram_we_o,
  output logic [1:0]      ex_b_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_rd1_o,
  output logic [XLEN-1:0] ex_rd2_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [REGW-1:0] ex_rs1_o,
  output logic [REGW-1:0] ex_rs2_o,
  output logic [REGW-1:0] ex_rd_o,
  output logic            ex_valid_o,
  output logic            stall_o,
  output logic [CNTW-1:0] bubble_cnt_o
);

  localparam int W = 7 + 2 + 1 + 2 + 3 + 3 + 1 + 1 + 1 + 2 + 4 * XLEN + 3 * REGW + 1;

  logic [W-1:0]    ex_d, ex_q;
  logic [CNTW-1:0] cnt_d, cnt_q;
  logic            hazard, bubble;
  logic            rf_we_m, branch_m, dram_we_m;
  logic [1:0]      npc_op_m;

  hazard_detect #(.REGW(REGW)) u_hazard (
    .id_opcode_i (id_opcode_i),
    .id_rs1_i    (id_rs1_i),
    .id_rs2_i    (id_rs2_i),
    .id_valid_i  (id_valid_i),
    .ex_valid_i  (ex_valid_o),
    .ex_rf_we_i  (ex_rf_we_o),
    .ex_wd_sel_i (ex_wd_sel_o),
    .ex_rd_i     (ex_rd_o),
    .hazard_o    (hazard)
  );

  assign bubble  = flush_i || hazard;
  assign stall_o = hazard && !flush_i;

  // An empty ID slot keeps its fields but must not write, store or redirect.
  always_comb begin
    rf_we_m   = id_valid_i ? id_rf_we_i   : 1'b0;
    branch_m  = id_valid_i ? id_branch_i  : 1'b0;
    dram_we_m = id_valid_i ? id_dram_we_i : 1'b0;
    npc_op_m  = id_valid_i ? id_npc_op_i  : NPC_PC4;
    ex_d = {id_opcode_i, npc_op_m, rf_we_m, id_wd_sel_i, id_sext_op_i, id_alu_op_i,
            id_alub_sel_i, branch_m, dram_we_m, id_b_i, id_pc_i, id_rd1_i, id_rd2_i,
            id_imm_i, id_rs1_i, id_rs2_i, id_rd_i, id_valid_i};
    cnt_d = cnt_q;
    if (bubble) begin
      ex_d  = '0;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign {ex_opcode_o, ex_npc_op_o, ex_rf_we_o, ex_wd_sel_o, ex_sext_op_o, ex_alu_op_o,
          ex_alub_sel_o, ex_branch_o, ex_dram_we_o, ex_b_o, ex_pc_o, ex_rd1_o, ex_rd2_o,
          ex_imm_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_valid_o} = ex_q;
  assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed bench for id_ex_stage (CNTW=4 so the counter wrap is reachable)
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int XLEN = 32;
  localparam int REGW = 5;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [6:0]      id_opcode;
  logic [1:0]      id_npc_op;
  logic            id_rf_we;
  logic [1:0]      id_wd_sel;
  logic [2:0]      id_sext_op;
  logic [2:0]      id_alu_op;
  logic            id_alub_sel;
  logic            id_branch;
  logic            id_dram_we;
  logic [1:0]      id_b;
  logic [XLEN-1:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [REGW-1:0] id_rs1, id_rs2, id_rd;
  logic            id_valid;
  logic            flush;
  logic [6:0]      ex_opcode;
  logic [1:0]      ex_npc_op;
  logic            ex_rf_we;
  logic [1:0]      ex_wd_sel;
  logic [2:0]      ex_sext_op;
  logic [2:0]      ex_alu_op;
  logic            ex_alub_sel;
  logic            ex_branch;
  logic            ex_dram_we;
  logic [1:0]      ex_b;
  logic [XLEN-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [REGW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic            ex_valid;
  logic            stall;
  logic [CNTW-1:0] bubble_cnt;

  int total = 0;
  int bad   = 0;
  logic [CNTW-1:0] exp_cnt;

  id_ex_stage #(.XLEN(XLEN), .REGW(REGW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .id_opcode_i(id_opcode), .id_npc_op_i(id_npc_op), .id_rf_we_i(id_rf_we),
    .id_wd_sel_i(id_wd_sel), .id_sext_op_i(id_sext_op), .id_alu_op_i(id_alu_op),
    .id_alub_sel_i(id_alub_sel), .id_branch_i(id_branch), .id_dram_we_i(id_dram_we),
    .id_b_i(id_b), .id_pc_i(id_pc), .id_rd1_i(id_rd1), .id_rd2_i(id_rd2),
    .id_imm_i(id_imm), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .id_valid_i(id_valid), .flush_i(flush),
    .ex_opcode_o(ex_opcode), .ex_npc_op_o(ex_npc_op), .ex_rf_we_o(ex_rf_we),
    .ex_wd_sel_o(ex_wd_sel), .ex_sext_op_o(ex_sext_op), .ex_alu_op_o(ex_alu_op),
    .ex_alub_sel_o(ex_alub_sel), .ex_branch_o(ex_branch), .ex_dram_we_o(ex_dram_we),
    .ex_b_o(ex_b), .ex_pc_o(ex_pc), .ex_rd1_o(ex_rd1), .ex_rd2_o(ex_rd2),
    .ex_imm_o(ex_imm), .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd),
    .ex_valid_o(ex_valid), .stall_o(stall), .bubble_cnt_o(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic we, input logic [1:0] wd);
    id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rf_we = we; id_wd_sel = wd; id_valid = 1'b1;
    id_npc_op = NPC_PC4; id_sext_op = 3'd0; id_alu_op = 3'd0; id_alub_sel = 1'b0;
    id_branch = 1'b0; id_dram_we = 1'b0; id_b = 2'd0;
    id_pc = 32'h0; id_rd1 = 32'h0; id_rd2 = 32'h0; id_imm = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'($urandom);
    id_opcode = 7'($urandom); id_npc_op = 2'($urandom); id_rf_we = 1'b1;
    id_wd_sel = 2'($urandom); id_sext_op = 3'($urandom); id_alu_op = 3'($urandom);
    id_alub_sel = 1'b1; id_branch = 1'b1; id_dram_we = 1'b1; id_b = 2'($urandom);
    id_pc = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
    id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_rd = 5'($urandom); id_valid = 1'b1;
    tick(); tick();
    total++;
    if ({ex_opcode, ex_npc_op, ex_rf_we, ex_wd_sel, ex_sext_op, ex_alu_op, ex_alub_sel,
         ex_branch, ex_dram_we, ex_b, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2,
         ex_rd, ex_valid} !== '0) begin
      bad++; $display("FAIL reset_fields: ex bundle nonzero (rf_we=%0b dram_we=%0b valid=%0b pc=%h)",
                      ex_rf_we, ex_dram_we, ex_valid, ex_pc);
    end
    total++;
    if (bubble_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", bubble_cnt); end
    rst = 1'b0; flush = 1'b0;
    set_id(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0); id_valid = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_pass_through();
    set_id(OP_I_TYPE, 5'd1, 5'd0, 5'd5, 1'b1, 2'b00);
    id_pc = 32'h10; id_imm = 32'd7; id_alub_sel = 1'b1; id_rd1 = 32'hAAAA_0001;
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL pass_stall: got %0b want 0", stall); end
    tick();
    total++;
    if (ex_rd !== 5'd5 || ex_imm !== 32'd7 || ex_alub_sel !== 1'b1 || ex_valid !== 1'b1 ||
        ex_pc !== 32'h10 || ex_rf_we !== 1'b1 || ex_rd1 !== 32'hAAAA_0001 || ex_opcode !== OP_I_TYPE) begin
      bad++; $display("FAIL pass_fields: rd=%0d imm=%0d alub=%0b valid=%0b pc=%h we=%0b want 5 7 1 1 00000010 1",
                      ex_rd, ex_imm, ex_alub_sel, ex_valid, ex_pc, ex_rf_we);
    end
  endtask

  task automatic test_load_use();
    set_id(OP_LW, 5'd1, 5'd0, 5'd3, 1'b1, WD_DRAM);
    tick();
    set_id(OP_R_TYPE, 5'd3, 5'd2, 5'd4, 1'b1, 2'b00);
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall: got %0b want 1", stall); end
    tick(); exp_cnt++;
    total++;
    if (ex_valid !== 1'b0 || ex_rf_we !== 1'b0 || bubble_cnt !== exp_cnt || ex_rd !== 5'd0) begin
      bad++; $display("FAIL lu_bubble: valid=%0b we=%0b cnt=%0d rd=%0d want 0 0 %0d 0",
                      ex_valid, ex_rf_we, bubble_cnt, ex_rd, exp_cnt);
    end
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL lu_release: got %0b want 0", stall); end
    tick();
    total++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd4 || ex_rs1 !== 5'd3 || ex_opcode !== OP_R_TYPE) begin
      bad++; $display("FAIL lu_latch: valid=%0b rd=%0d rs1=%0d want 1 4 3", ex_valid, ex_rd, ex_rs1);
    end
  endtask

  task automatic test_no_false_hazard();
    set_id(OP_LW, 5'd1, 5'd0, 5'd0, 1'b1, WD_DRAM);
    tick();
    set_id(OP_R_TYPE, 5'd0, 5'd0, 5'd6, 1'b1, 2'b00);
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL nf_x0: got %0b want 0", stall); end
    tick();
    set_id(OP_LW, 5'd1, 5'd0, 5'd3, 1'b1, WD_DRAM);
    tick();
    set_id(OP_LUI, 5'd3, 5'd3, 5'd3, 1'b1, 2'b11);
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL nf_lui: got %0b want 0", stall); end
    tick();
    set_id(OP_LW, 5'd1, 5'd0, 5'd3, 1'b1, WD_DRAM);
    tick();
    set_id(OP_SW, 5'd1, 5'd3, 5'd0, 1'b0, 2'b00);
    id_dram_we = 1'b1;
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL nf_sw_rs2: got %0b want 1", stall); end
    tick(); exp_cnt++;
    total++;
    if (bubble_cnt !== exp_cnt || ex_dram_we !== 1'b0) begin
      bad++; $display("FAIL nf_sw_bubble: cnt=%0d dram_we=%0b want %0d 0", bubble_cnt, ex_dram_we, exp_cnt);
    end
    tick();
    total++;
    if (ex_dram_we !== 1'b1 || ex_valid !== 1'b1 || ex_rs2 !== 5'd3) begin
      bad++; $display("FAIL nf_sw_latch: dram_we=%0b valid=%0b rs2=%0d want 1 1 3", ex_dram_we, ex_valid, ex_rs2);
    end
  endtask

  task automatic test_flush_priority();
    set_id(OP_LW, 5'd1, 5'd0, 5'd3, 1'b1, WD_DRAM);
    tick();
    set_id(OP_R_TYPE, 5'd3, 5'd2, 5'd4, 1'b1, 2'b00);
    id_dram_we = 1'b1; id_npc_op = NPC_JALR; id_branch = 1'b1;
    flush = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL fl_stall: got %0b want 0", stall); end
    tick(); exp_cnt++;
    flush = 1'b0;
    total++;
    if (ex_valid !== 1'b0 || ex_dram_we !== 1'b0 || ex_npc_op !== 2'b00 ||
        ex_branch !== 1'b0 || bubble_cnt !== exp_cnt) begin
      bad++; $display("FAIL fl_bubble: valid=%0b dram_we=%0b npc=%0d br=%0b cnt=%0d want 0 0 0 0 %0d",
                      ex_valid, ex_dram_we, ex_npc_op, ex_branch, bubble_cnt, exp_cnt);
    end
  endtask

  task automatic test_invalid_input();
    set_id(OP_B_TYPE, 5'd1, 5'd2, 5'd7, 1'b1, 2'b01);
    id_dram_we = 1'b1; id_branch = 1'b1; id_npc_op = NPC_BR; id_imm = 32'h1234;
    id_valid = 1'b0;
    tick();
    total++;
    if (ex_rd !== 5'd7 || ex_imm !== 32'h1234 || ex_rf_we !== 1'b0 || ex_dram_we !== 1'b0 ||
        ex_branch !== 1'b0 || ex_npc_op !== 2'b00 || ex_valid !== 1'b0 || bubble_cnt !== exp_cnt) begin
      bad++; $display("FAIL inv_capture: rd=%0d imm=%h we=%0b dw=%0b br=%0b npc=%0d v=%0b cnt=%0d",
                      ex_rd, ex_imm, ex_rf_we, ex_dram_we, ex_branch, ex_npc_op, ex_valid, bubble_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    flush = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    total++;
    if (bubble_cnt !== 4'd15) begin bad++; $display("FAIL wrap_15: got %0d want 15", bubble_cnt); end
    tick();
    total++;
    if (bubble_cnt !== 4'd0) begin bad++; $display("FAIL wrap_0: got %0d want 0", bubble_cnt); end
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    set_id(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0);
    #2;
    test_reset();
    test_pass_through();
    test_load_use();
    test_no_false_hazard();
    test_flush_priority();
    test_invalid_input();
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core. Sits directly downstream of the instruction decoder and upstream of the EX stage.
- Each cycle it latches the decoded control bundle and the ID operands (PC, register data, immediate, register indices) into EX-stage registers.
- Contains load-use hazard detection. On a hazard it drives a stall request to the PC and IF/ID stage, and inserts a bubble into EX.
- Accepts a flush from EX on a taken branch or jump, and counts inserted bubbles for performance debug.

Parameters:
- XLEN, 32, datapath width
- REGW, 5, register index width
- CNTW, 32, bubble counter width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_opcode_i  in  7  opcode of the instruction in ID
- id_npc_op_i  in  2  next-PC select (00 PC4, 01 branch, 10 jal, 11 jalr)
- id_rf_we_i  in  1  register file write enable
- id_wd_sel_i  in  2  write-data select (00 ALU, 01 PC+4, 10 DRAM, 11 imm)
- id_sext_op_i  in  3  immediate format
- id_alu_op_i  in  3  ALU operation
- id_alub_sel_i  in  1  ALU B source (1 = imm)
- id_branch_i  in  1  conditional branch
- id_dram_we_i  in  1  store enable
- id_b_i  in  2  branch condition (00 beq, 01 bne, 10 blt, 11 bge)
- id_pc_i  in  XLEN  instruction PC
- id_rd1_i, id_rd2_i  in  XLEN  register read data
- id_imm_i  in  XLEN  extended immediate
- id_rs1_i, id_rs2_i, id_rd_i  in  REGW  register indices
- id_valid_i  in  1  ID holds a real instruction
- flush_i  in  1  EX redirect (taken branch/jal/jalr)
- ex_*_o  out  —  registered copies of every id_* control/data input above (same widths)
- ex_valid_o  out  1  EX holds a real instruction
- stall_o  out  1  hold PC and IF/ID this cycle
- bubble_cnt_o  out  CNTW  total bubbles inserted

Behaviour:
- Reset (rst=1 at a posedge):
  - All ex_* outputs clear to 0, ex_valid_o=0, bubble_cnt_o=0.
  - npc_op 00 and all write enables 0, so the reset state is a bubble.
- Source-use decode, from id_opcode_i:
  - R_TYPE, SW, B_TYPE use rs1 and rs2.
  - I_TYPE, LW, JALR use rs1 only.
  - LUI, JAL and all other opcodes use neither.
- Load-use hazard (combinational):
  - Condition: ex_valid_o & ex_rf_we_o & ex_wd_sel_o==10 & ex_rd_o!=0 & id_valid_i, and the ID instruction uses a source register equal to ex_rd_o.
- stall_o = hazard & ~flush_i, asserted in the same cycle as the hazard. This is a 1-cycle penalty: next cycle the load sits in MEM, so the hazard clears.
- Next-state priority at each posedge:
  - rst: reset values as above.
  - flush_i: load a bubble.
  - hazard: load a bubble.
  - otherwise: load all id_* inputs, with ex_valid_o = id_valid_i.
- Bubble contents:
  - ex_valid_o=0, rf_we=0, dram_we=0, branch=0, npc_op=00.
  - Data and index fields are cleared to 0. The bubble must never write a register or memory, or redirect the PC.
- Invalid ID input (id_valid_i=0, no flush/hazard): the fields are captured as-is, but rf_we, dram_we and branch are forced to 0 and npc_op to 00.
- bubble_cnt_o increments by 1 on every posedge that loads a bubble due to flush_i or hazard, not on the reset load. It wraps from 2^CNTW-1 to 0.
- Simultaneous flush_i and hazard: one bubble is inserted, the counter increments by 1, and stall_o=0.
- rst asserted mid-stall: reset wins and stall_o is don't-care during reset.
- No X propagation: decoder X outputs on an unknown opcode are captured, but the enables are forced to 0 whenever id_valid_i=0.

Decomposition:
- param.v (shared include):
  - Existing opcode macros (R_TYPE, I_TYPE, LW, SW, JALR, B_TYPE, LUI, JAL) and PC4.
  - New macros: WD_DRAM=2'b10, NPC_BR/NPC_JAL/NPC_JALR.
- One natural sub-module: hazard_detect, purely combinational. It computes rs1/rs2 usage and the hazard flag; id_ex_stage instantiates it and owns all registers and the counter.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random inputs -> all ex_* outputs 0, ex_valid_o=0, bubble_cnt_o=0, no spurious writes.
- Pass-through: addi x5,x1,7 (pc=0x10, imm=7, rd=5) with id_valid_i=1 -> one cycle later ex_rd_o=5, ex_imm_o=7, ex_alub_sel_o=1, ex_valid_o=1, stall_o=0.
- Load-use: lw x3 in EX, add x4,x3,x2 in ID -> stall_o=1 that cycle; next cycle ex_valid_o=0, ex_rf_we_o=0, bubble_cnt_o=1; the following cycle the add is latched.
- No false hazard:
  - lw x0 followed by a use of x0 -> stall_o=0.
  - lw x3 followed by lui x3 -> stall_o=0.
  - lw x3 followed by sw with rs2=x3 -> stall_o=1.
- Flush priority: flush_i=1 together with a load-use hazard -> stall_o=0, a single bubble, bubble_cnt_o incremented by exactly 1, ex_dram_we_o=0, ex_npc_op_o=00.
- Counter wrap: CNTW=4, apply 16 bubbles -> bubble_cnt_o returns to 0.
